// File: rtl/x7seg_pkg.sv
// Shared types and active-high glyph constants for the multiplexed 7-segment driver.
// Segment bit order: bit 0 = a ... bit 6 = g, bit 7 = decimal point.
package x7seg_pkg;

    typedef logic [7:0] seg_t;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam seg_t SEG_OFF = 8'h00;
    localparam seg_t GLYPH_0 = 8'h3F;
    localparam seg_t GLYPH_1 = 8'h06;
    localparam seg_t GLYPH_2 = 8'h5B;
    localparam seg_t GLYPH_3 = 8'h4F;
    localparam seg_t GLYPH_4 = 8'h66;
    localparam seg_t GLYPH_5 = 8'h6D;
    localparam seg_t GLYPH_6 = 8'h7D;
    localparam seg_t GLYPH_7 = 8'h07;
    localparam seg_t GLYPH_8 = 8'h7F;
    localparam seg_t GLYPH_9 = 8'h6F;
    localparam seg_t GLYPH_A = 8'h77;
    localparam seg_t GLYPH_B = 8'h7C;
    localparam seg_t GLYPH_C = 8'h39;
    localparam seg_t GLYPH_D = 8'h5E;
    localparam seg_t GLYPH_E = 8'h79;
    localparam seg_t GLYPH_F = 8'h71;

endpackage

// File: rtl/x7seg_glyph.sv
// Combinational hex nibble to active-high segment pattern; the dp bit is always clear here.
module x7seg_glyph
    import x7seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       glyph
);

    always_comb begin
        glyph = SEG_OFF;
        case (nibble)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = GLYPH_A;
            4'hB: glyph = GLYPH_B;
            4'hC: glyph = GLYPH_C;
            4'hD: glyph = GLYPH_D;
            4'hE: glyph = GLYPH_E;
            4'hF: glyph = GLYPH_F;
            default: glyph = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/x7seg_scan_driver.sv
// N-digit multiplexed 7-segment scanner with frame-boundary commit of new content,
// anode guard interval against ghosting and optional leading-zero blanking.
module x7seg_scan_driver
    import x7seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic [NUM_DIGITS-1:0]   wr_dp,
    input  logic                    wr_blank_lz,
    input  logic                    enable,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg,
    output logic                    scan_wrap
);

    localparam int PCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DATA_W = 4 * NUM_DIGITS;
    localparam logic POL  = (ACTIVE_LOW != 0);

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(REFRESH_DIV - 1);
    localparam logic [PCNT_W-1:0] GUARD_END = PCNT_W'(GUARD);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("x7seg_scan_driver: NUM_DIGITS must be in 1..8");
    end
    if (GUARD < 0 || REFRESH_DIV < GUARD + 2) begin : g_bad_refresh_div
        $error("x7seg_scan_driver: REFRESH_DIV must be at least GUARD+2");
    end

    logic [PCNT_W-1:0]     pcnt_reg;
    logic [DIG_W-1:0]      dig_reg;
    logic [DATA_W-1:0]     disp_data_reg;
    logic [NUM_DIGITS-1:0] disp_dp_reg;
    logic [NUM_DIGITS-1:0] mask_reg;
    logic [DATA_W-1:0]     shadow_data_reg;
    logic [NUM_DIGITS-1:0] shadow_dp_reg;
    logic                  shadow_lz_reg;
    logic                  pending_reg;
    logic                  scan_wrap_reg;
    logic [NUM_DIGITS-1:0] an_reg;
    logic [7:0]            seg_reg;

    logic                  tick;
    logic                  wrap;
    logic                  handshake;
    logic                  commit;
    logic [PCNT_W-1:0]     pcnt_next;
    logic [DIG_W-1:0]      dig_next;
    logic [DATA_W-1:0]     disp_data_next;
    logic [NUM_DIGITS-1:0] disp_dp_next;
    logic [NUM_DIGITS-1:0] mask_next;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic [3:0]            nibble;
    logic                  dp_bit;
    logic                  blank_bit;
    seg_t                  glyph;
    seg_t                  seg_hi;
    logic [NUM_DIGITS-1:0] an_hi;
    logic [NUM_DIGITS-1:0] an_next;
    logic [7:0]            seg_next;
    logic [3:0]            nib_arr [NUM_DIGITS];

    assign tick      = (pcnt_reg == PCNT_LAST);
    assign wrap      = tick && (dig_reg == DIG_LAST);
    assign handshake = wr_valid && !pending_reg;
    // A handshake landing on the wrap tick cannot commit there: pending was still clear.
    assign commit    = wrap && pending_reg;

    assign pcnt_next = tick ? '0 : pcnt_reg + PCNT_W'(1);
    assign dig_next  = !tick ? dig_reg : (wrap ? '0 : dig_reg + DIG_W'(1));

    always_comb begin
        logic run;
        lz_mask = '0;
        run     = shadow_lz_reg;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run        = run && (shadow_data_reg[4*i +: 4] == 4'h0) && !shadow_dp_reg[i];
            lz_mask[i] = run;
        end
    end

    assign disp_data_next = commit ? shadow_data_reg : disp_data_reg;
    assign disp_dp_next   = commit ? shadow_dp_reg   : disp_dp_reg;
    assign mask_next      = commit ? lz_mask         : mask_reg;

    // Outputs are built from next-state values so they land on the same edge as pcnt/dig.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
        assign nib_arr[gi] = disp_data_next[4*gi +: 4];
    end

    assign nibble    = nib_arr[dig_next];
    assign dp_bit    = disp_dp_next[dig_next];
    assign blank_bit = mask_next[dig_next];

    x7seg_glyph u_glyph (
        .nibble (nibble),
        .glyph  (glyph)
    );

    always_comb begin
        seg_hi = SEG_OFF;
        an_hi  = '0;
        if (!blank_bit && enable) begin
            seg_hi         = glyph;
            seg_hi[SEG_DP] = dp_bit;
            if (pcnt_next >= GUARD_END) begin
                an_hi = NUM_DIGITS'(1) << dig_next;
            end
        end
    end

    assign an_next  = an_hi ^ {NUM_DIGITS{POL}};
    assign seg_next = seg_hi ^ {8{POL}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_reg        <= '0;
            dig_reg         <= '0;
            disp_data_reg   <= '0;
            disp_dp_reg     <= '0;
            mask_reg        <= '0;
            shadow_data_reg <= '0;
            shadow_dp_reg   <= '0;
            shadow_lz_reg   <= 1'b0;
            pending_reg     <= 1'b0;
            scan_wrap_reg   <= 1'b0;
            an_reg          <= {NUM_DIGITS{POL}};
            seg_reg         <= SEG_OFF ^ {8{POL}};
        end else begin
            pcnt_reg      <= pcnt_next;
            dig_reg       <= dig_next;
            scan_wrap_reg <= wrap;
            disp_data_reg <= disp_data_next;
            disp_dp_reg   <= disp_dp_next;
            mask_reg      <= mask_next;
            an_reg        <= an_next;
            seg_reg       <= seg_next;
            if (handshake) begin
                shadow_data_reg <= wr_data;
                shadow_dp_reg   <= wr_dp;
                shadow_lz_reg   <= wr_blank_lz;
                pending_reg     <= 1'b1;
            end else if (commit) begin
                pending_reg <= 1'b0;
            end
        end
    end

    assign wr_ready  = !pending_reg;
    assign an        = an_reg;
    assign seg       = seg_reg;
    assign scan_wrap = scan_wrap_reg;

endmodule
